// File: rtl/rotozoom_pkg.sv
// Shared types and constants for the rotozoom parameter sequencer.
package rotozoom_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSinReq,
    StSinWait,
    StCosReq,
    StCosWait,
    StCommit
  } seq_state_e;

  localparam int unsigned HActiveDefault = 640;
  localparam int unsigned VActiveDefault = 480;
  localparam int unsigned AngleWDefault  = 8;
  localparam int unsigned QuarterOffset  = 1 << (AngleWDefault - 2);

  // Quarter period of the sine table: cos(a) = sin(a + 2^(w-2)).
  function automatic int unsigned quarter_offset(int unsigned angle_w);
    return 1 << (angle_w - 2);
  endfunction

endpackage

// File: rtl/rotozoom_param_sequencer_if.sv
// Shared sine ROM bus: the sequencer drives the address, the ROM returns signed data.
interface rotozoom_param_sequencer_if
  import rotozoom_pkg::*;
#(
  parameter int unsigned ANGLE_W = AngleWDefault,
  parameter int unsigned COEF_W  = 16
);
  logic        [ANGLE_W-1:0] rom_addr;
  logic signed [COEF_W-1:0]  rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/rotozoom_strobe_gen.sv
// Registered accumulator strobes derived from the raster position; one is high per cycle.
module rotozoom_strobe_gen (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [9:0] hpos_i,
  input  logic [9:0] vpos_i,
  output logic       acc_clr_o,
  output logic       acc_line_o,
  output logic       acc_pix_o
);
  logic clr_d, line_d, pix_d;
  logic clr_q, line_q, pix_q;

  always_comb begin
    clr_d  = (hpos_i == '0) && (vpos_i == '0);
    line_d = (hpos_i == '0) && (vpos_i != '0);
    pix_d  = (hpos_i != '0);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clr_q  <= 1'b0;
      line_q <= 1'b0;
      pix_q  <= 1'b0;
    end else begin
      clr_q  <= clr_d;
      line_q <= line_d;
      pix_q  <= pix_d;
    end
  end

  assign acc_clr_o  = clr_q;
  assign acc_line_o = line_q;
  assign acc_pix_o  = pix_q;
endmodule

// File: rtl/rotozoom_param_sequencer.sv
// Per-frame angle update, shared sine-ROM fetch of sin/cos, zoom and atomic
// coefficient commit during vblank, plus accumulator step strobes.
module rotozoom_param_sequencer
  import rotozoom_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDefault,
  parameter int unsigned V_ACTIVE = VActiveDefault,
  parameter int unsigned ANGLE_W  = AngleWDefault,
  parameter int unsigned COEF_W   = 16,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [9:0]          hpos,
  input  logic [9:0]          vpos,
  input  logic [2:0]          speed,
  input  logic                dir,
  input  logic                pause,
  input  logic [1:0]          zoom,
  rotozoom_param_sequencer_if.master rom,
  output logic [COEF_W-1:0]   sin_coef,
  output logic [COEF_W-1:0]   cos_coef,
  output logic                coef_valid,
  output logic                coef_update,
  output logic [10:0]         frame,
  output logic                acc_clr,
  output logic                acc_line,
  output logic                acc_pix,
  output logic                overrun
);
  if (H_ACTIVE >= 1024 || V_ACTIVE >= 1024 || ROM_LAT > 3) begin : g_bad_param
    $error("rotozoom_param_sequencer: unsupported parameter value");
  end

  localparam logic [ANGLE_W-1:0] Quarter  = ANGLE_W'(quarter_offset(ANGLE_W));
  localparam bit                 NoWait   = (ROM_LAT == 0);
  localparam logic [1:0]         LastWait = (ROM_LAT == 0) ? 2'd0 : 2'(ROM_LAT - 1);

  seq_state_e state_q, state_d;

  logic        [ANGLE_W-1:0] angle_q, angle_d, rom_addr_q, rom_addr_d, step;
  logic        [10:0]        frame_q, frame_d;
  logic        [1:0]         zoom_q, zoom_d, wait_cnt_q, wait_cnt_d;
  logic signed [COEF_W-1:0]  sin_work_q, sin_work_d, cos_work_q, cos_work_d;
  logic        [COEF_W-1:0]  sin_coef_q, sin_coef_d, cos_coef_q, cos_coef_d;
  logic                      valid_q, valid_d, update_q, update_d, overrun_q, overrun_d;
  logic                      frame_tick, wait_done;

  assign frame_tick = (vpos == 10'(V_ACTIVE)) && (hpos == '0);
  assign wait_done  = (wait_cnt_q == LastWait);
  assign step       = ANGLE_W'(speed);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (frame_tick) state_d = StSinReq;
      StSinReq:  state_d = NoWait ? StCosReq : StSinWait;
      StSinWait: if (wait_done) state_d = StCosReq;
      StCosReq:  state_d = NoWait ? StCommit : StCosWait;
      StCosWait: if (wait_done) state_d = StCommit;
      StCommit:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    angle_d    = angle_q;
    frame_d    = frame_q;
    zoom_d     = zoom_q;
    rom_addr_d = rom_addr_q;
    wait_cnt_d = '0;
    sin_work_d = sin_work_q;
    cos_work_d = cos_work_q;
    sin_coef_d = sin_coef_q;
    cos_coef_d = cos_coef_q;
    valid_d    = valid_q;
    update_d   = 1'b0;
    // Ticks arriving mid-sequence are dropped but remembered.
    overrun_d  = overrun_q | (frame_tick && (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (frame_tick) begin
          frame_d = frame_q + 11'd1;
          if (!pause) angle_d = dir ? (angle_q - step) : (angle_q + step);
          zoom_d     = zoom;
          rom_addr_d = angle_d;
        end
      end
      StSinReq: begin
        if (NoWait) begin
          sin_work_d = rom.rom_data;
          rom_addr_d = angle_q + Quarter;
        end
      end
      StSinWait: begin
        wait_cnt_d = wait_cnt_q + 2'd1;
        if (wait_done) begin
          sin_work_d = rom.rom_data;
          rom_addr_d = angle_q + Quarter;
          wait_cnt_d = '0;
        end
      end
      StCosReq: begin
        if (NoWait) cos_work_d = rom.rom_data;
      end
      StCosWait: begin
        wait_cnt_d = wait_cnt_q + 2'd1;
        if (wait_done) begin
          cos_work_d = rom.rom_data;
          wait_cnt_d = '0;
        end
      end
      StCommit: begin
        sin_coef_d = sin_work_q >>> zoom_q;
        cos_coef_d = cos_work_q >>> zoom_q;
        valid_d    = 1'b1;
        update_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      angle_q    <= '0;
      frame_q    <= '0;
      zoom_q     <= '0;
      rom_addr_q <= '0;
      wait_cnt_q <= '0;
      sin_work_q <= '0;
      cos_work_q <= '0;
      sin_coef_q <= '0;
      cos_coef_q <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      angle_q    <= angle_d;
      frame_q    <= frame_d;
      zoom_q     <= zoom_d;
      rom_addr_q <= rom_addr_d;
      wait_cnt_q <= wait_cnt_d;
      sin_work_q <= sin_work_d;
      cos_work_q <= cos_work_d;
      sin_coef_q <= sin_coef_d;
      cos_coef_q <= cos_coef_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rom.rom_addr = rom_addr_q;
  assign sin_coef     = sin_coef_q;
  assign cos_coef     = cos_coef_q;
  assign coef_valid   = valid_q;
  assign coef_update  = update_q;
  assign frame        = frame_q;
  assign overrun      = overrun_q;

  rotozoom_strobe_gen u_strobe_gen (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .hpos_i     (hpos),
    .vpos_i     (vpos),
    .acc_clr_o  (acc_clr),
    .acc_line_o (acc_line),
    .acc_pix_o  (acc_pix)
  );
endmodule

// File: doc/rotozoom_param_sequencer.md
Name: rotozoom_param_sequencer

Overview:
Frame-rate controller for the rotozoom datapath. Once per frame it advances a rotation angle, time-shares one sine ROM to fetch sin and cos, applies zoom and commits the coefficients atomically during vertical blanking. It also issues registered clear/line-step/pixel-step strobes to the per-pixel rotation accumulators. It sits between the hvsync generator and the accumulators, replacing the two free-running LUT instances with one shared ROM.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines; vpos==V_ACTIVE marks vblank start
ANGLE_W, 8, angle/ROM address width (full period = 2^ANGLE_W)
COEF_W, 16, signed coefficient width (ROM data width)
ROM_LAT, 1, sine ROM read latency in cycles (0..3)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
hpos  in  10  horizontal pixel position
vpos  in  10  vertical line position
speed  in  3  angle increment per frame (unsigned)
dir  in  1  0 = angle += speed, 1 = angle -= speed
pause  in  1  1 = hold angle (coefficients still refreshed)
zoom  in  2  arithmetic right shift applied to coefficients
rom_addr  out  ANGLE_W  shared sine ROM address
rom_data  in  COEF_W  signed ROM output, valid ROM_LAT cycles after rom_addr
sin_coef  out  COEF_W  committed signed sine coefficient
cos_coef  out  COEF_W  committed signed cosine coefficient
coef_valid  out  1  high from first commit onward
coef_update  out  1  one-cycle pulse on commit
frame  out  11  frame counter
acc_clr  out  1  accumulator clear (frame origin)
acc_line  out  1  line step
acc_pix  out  1  pixel step
overrun  out  1  sticky: frame tick arrived while FSM busy

Behaviour:
- Reset (rst_n low at clk edge): angle=0, frame=0, FSM=IDLE, rom_addr=0, sin_coef=0, cos_coef=0, coef_valid=0, coef_update=0, overrun=0, strobes=0. Reset mid-sequence aborts with no commit.
- frame_tick (internal) = (vpos==V_ACTIVE && hpos==0). At most one per frame.
- On frame_tick in IDLE:
  - frame += 1, wrapping at 2^11.
  - If !pause: angle ±= speed, modulo 2^ANGLE_W.
  - Latch zoom into zoom_q.
  - Go to SIN_REQ using the new angle.
- On frame_tick in any non-IDLE state: ignored entirely (angle and frame unchanged), overrun<=1. Only reset clears overrun.
- FSM: IDLE -> SIN_REQ -> SIN_WAIT -> COS_REQ -> COS_WAIT -> COMMIT -> IDLE.
  - SIN_REQ: rom_addr=angle.
  - COS_REQ: rom_addr=angle+2^(ANGLE_W-2), modulo.
  - *_WAIT: hold rom_addr for ROM_LAT cycles (counter), then capture rom_data into a work register. With ROM_LAT=0, capture in the REQ cycle and skip WAIT.
  - COMMIT: sin_coef<=sin_work>>>zoom_q, cos_coef<=cos_work>>>zoom_q (sign-preserving), coef_update=1 for this cycle, coef_valid<=1.
  - rom_addr holds its last value in IDLE.
- Sequence length: 2*(ROM_LAT+1)+1 cycles, far shorter than vblank, so coefficients never change during active video.
- Strobes, registered with 1-cycle latency relative to hpos/vpos:
  - acc_clr = (hpos==0 && vpos==0)
  - acc_line = (hpos==0 && vpos!=0)
  - acc_pix = (hpos!=0)
  - Exactly one strobe is high each cycle after reset.
- All arithmetic is modulo its width; no saturation.

Decomposition:
- Shared package rotozoom_pkg holds:
  - FSM state enum (3-bit).
  - Quarter-period offset constant 2^(ANGLE_W-2).
  - Default H_ACTIVE/V_ACTIVE.
- One natural sub-module, rotozoom_strobe_gen (hpos/vpos -> registered acc_clr/acc_line/acc_pix). The FSM stays in the top module.
- The sine ROM stays outside the block and is driven through rom_addr/rom_data.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with arbitrary hpos/vpos -> all outputs 0 and FSM in IDLE. First cycle after release with hpos=0, vpos=0 -> next cycle acc_clr=1.
- Normal frame (ROM_LAT=1, speed=1, dir=0, zoom=0; ROM model returns addr*4) -> rom_addr=1 then 65, sin_coef=4, cos_coef=260, coef_update pulses once 5 cycles after tick, frame=1, coef_valid=1.
- Zoom and sign: ROM returns -16 for both fetches, zoom=2 -> sin_coef=cos_coef=-4 (0xFFFC).
- Wrap and direction: angle=255, speed=1, dir=0 -> angle=0, cos addr=64. Then speed=3, dir=1 -> angle=253, cos addr=61 (317 mod 256).
- Pause/overrun: pause=1 over 3 frames -> angle constant, coef_update still pulses each frame. Force a second vpos=480/hpos=0 one cycle after a tick -> overrun=1, frame incremented only once.
- Reset mid-sequence: assert rst_n=0 during COS_WAIT -> no coef_update, sin_coef and cos_coef stay 0, next tick performs a full clean sequence.
